audio_sequencer: RTL and testbench
==================================

AUDIO_SEQUENCER -- requirements
Module: audio_sequencer

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent voices, 1..8.
REQ-002 Parameter FRAME_BITS, default 3: frame index width; table depth per channel is 2**FRAME_BITS.
REQ-003 Parameter PERIOD_BITS, default 16: half-period field width.
REQ-004 Parameter DUR_BITS, default 10: duration field width.
REQ-005 Parameter TICK_DIV, default 48828: CLK cycles per sequencer tick.
REQ-006 Parameter SAMPLE_DIV, default 128: CLK cycles per synth sample step.
REQ-007 Parameter MEM_FILE, default "audio-frames.dat": hex init file; entry [ch*2**FRAME_BITS + f] = {period, dur}.
REQ-008 CLK  in  1  sole clock; everything on rising edge.
REQ-009 RESET  in  1  synchronous, active-high reset.
REQ-010 START  in  1  one-cycle pulse: restart all channels at frame 0.
REQ-011 STOP  in  1  one-cycle pulse: halt all channels, silence output.
REQ-012 LOOP  in  1  level; sampled at each end marker.
REQ-013 BUSY  out  1  high while any channel is playing.
REQ-014 LEVEL  out  clog2(CHANNELS+1)  count of channel square outputs currently high.
REQ-015 AUDIO  out  1  first-order sigma-delta bitstream of LEVEL/CHANNELS.

Function
REQ-016 Tick counter runs only while BUSY, counts 0..TICK_DIV-1, asserts tick on TICK_DIV-1, then wraps; it clears on START.
REQ-017 Sample counter free-runs 0..SAMPLE_DIV-1, sample step on SAMPLE_DIV-1.
REQ-018 Per channel, states: IDLE, PLAY, DONE.
REQ-019 START (any state) -> PLAY, frame=0, framePos=0, period loaded from frame 0 on the same edge, square output 0, phase counter 0.
REQ-020 In PLAY on tick: if framePos==dur then framePos=0 and frame advances, else framePos increments; frame length is dur+1 ticks.
REQ-021 Advancing into a frame loads its period on that tick edge; period change resets phase counter to 0 and square output to 0.
REQ-022 Period 0 with dur nonzero = rest: square held 0 for dur+1 ticks.
REQ-023 Entry {0,0} = end marker: on reaching it, LOOP=1 -> frame 0 loaded on the same edge; LOOP=0 -> DONE.
REQ-024 Frame index at 2**FRAME_BITS-1 without a marker wraps to 0 (implicit loop regardless of LOOP).
REQ-025 Square: on sample step with period P!=0, phase counter increments; at P-1 it clears and square output toggles.
REQ-026 IDLE and DONE: square 0, counters frozen.
REQ-027 STOP -> all channels IDLE on next edge; STOP wins over simultaneous START.
REQ-028 BUSY = OR over channels of (state==PLAY), registered, one cycle after state change.
REQ-029 LEVEL registered sum of square outputs; AUDIO from accumulator width clog2(CHANNELS+1)+1: acc += LEVEL each cycle, AUDIO=1 and acc -= CHANNELS when acc >= CHANNELS.
REQ-030 Table is read-only ROM, read combinationally or with one-cycle latency as long as REQ-019/REQ-021 timing holds.

Reset
REQ-031 RESET: all channels IDLE, frame/framePos/phase/tick/sample counters 0, BUSY=0, LEVEL=0, AUDIO=0, accumulator 0.
REQ-032 RESET dominates START and STOP in the same cycle; reset mid-note silences output on the next edge.

Structure
REQ-033 Package audio_pkg: field widths, end-marker constant, channel state encoding.
REQ-034 One sub-module audio_voice (per-channel sequencer + square synth), instantiated CHANNELS times; tick and sample dividers shared at top.

Verification (bench: CHANNELS=2, TICK_DIV=4, SAMPLE_DIV=2)
REQ-035 Ch0 {P=3,D=1},{0,0}; START, LOOP=0 -> square toggles every 6 CLK for 8 CLK of play, then DONE, BUSY falls.
REQ-036 Same table, LOOP=1 -> frame 0 reloaded on marker tick, BUSY stays 1 for 100 ticks.
REQ-037 Ch1 rest {0,D=2} then {P=1,D=0} -> square 0 for 12 CLK, then toggles every 2 CLK.
REQ-038 Both channels P=1 in phase -> LEVEL alternates 0/2, AUDIO density 50% over 64 cycles.
REQ-039 STOP and START same cycle mid-note -> all IDLE, AUDIO 0; RESET mid-play -> all outputs 0 next edge.
REQ-040 Table with no marker, 8 frames D=0 -> frame index wraps 7->0 without stopping.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared field widths, end-marker constant and voice state encoding
package audio_pkg;

    localparam int DEF_FRAME_BITS  = 3;
    localparam int DEF_PERIOD_BITS = 16;
    localparam int DEF_DUR_BITS    = 10;

    // A table entry of all zeros ({period 0, dur 0}) terminates a channel's sequence.
    localparam logic [63:0] END_MARKER = 64'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_end_marker(input logic [63:0] entry);
        return entry == END_MARKER;
    endfunction

endpackage

// File: rtl/audio_voice.sv
// rtl/audio_voice.sv - one channel: frame sequencer walking its ROM slice plus square-wave synth
module audio_voice
    import audio_pkg::*;
#(
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int PERIOD_BITS = DEF_PERIOD_BITS,
    parameter int DUR_BITS    = DEF_DUR_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    input  logic loop,
    input  logic tick,
    input  logic sample_step,
    input  logic [(2**FRAME_BITS)*(PERIOD_BITS+DUR_BITS)-1:0] frames,
    output logic square,
    output logic playing
);

    localparam int EW = PERIOD_BITS + DUR_BITS;

    logic [1:0]             state;
    logic [FRAME_BITS-1:0]  frame;
    logic [DUR_BITS-1:0]    frame_pos;
    logic [PERIOD_BITS-1:0] period;
    logic [PERIOD_BITS-1:0] phase;

    logic [FRAME_BITS-1:0]  next_frame;
    logic [EW-1:0]          next_entry;
    logic [DUR_BITS-1:0]    cur_dur;
    logic [PERIOD_BITS-1:0] next_period;
    logic [PERIOD_BITS-1:0] first_period;
    logic                   next_is_end;
    logic                   frame_done;

    // Combinational ROM reads so a new period lands on the same edge as the frame change.
    always_comb begin
        next_frame   = frame + 1'b1;
        cur_dur      = frames[int'(frame) * EW +: DUR_BITS];
        next_entry   = frames[int'(next_frame) * EW +: EW];
        next_period  = next_entry[EW-1:DUR_BITS];
        first_period = frames[EW-1:DUR_BITS];
        next_is_end  = is_end_marker(64'(next_entry));
        frame_done   = tick && (frame_pos == cur_dur);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            frame     <= '0;
            frame_pos <= '0;
            period    <= '0;
            phase     <= '0;
            square    <= 1'b0;
        end else if (stop) begin
            state  <= ST_IDLE;
            square <= 1'b0;
        end else if (start) begin
            state     <= ST_PLAY;
            frame     <= '0;
            frame_pos <= '0;
            period    <= first_period;
            phase     <= '0;
            square    <= 1'b0;
        end else if (state == ST_PLAY) begin
            if (frame_done) begin
                // Every frame load restarts the waveform, even if the period is unchanged.
                frame_pos <= '0;
                phase     <= '0;
                square    <= 1'b0;
                if (!next_is_end) begin
                    frame  <= next_frame;
                    period <= next_period;
                end else if (loop) begin
                    frame  <= '0;
                    period <= first_period;
                end else begin
                    state <= ST_DONE;
                end
            end else begin
                if (tick) begin
                    frame_pos <= frame_pos + 1'b1;
                end
                if (sample_step && (period != '0)) begin
                    if (phase == period - 1'b1) begin
                        phase  <= '0;
                        square <= ~square;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
            end
        end
    end

    assign playing = (state == ST_PLAY);

endmodule

// File: rtl/audio_sequencer.sv
// rtl/audio_sequencer.sv - multi-voice ROM-driven square-wave sequencer with sigma-delta output
module audio_sequencer
    import audio_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int PERIOD_BITS = DEF_PERIOD_BITS,
    parameter int DUR_BITS    = DEF_DUR_BITS,
    parameter int TICK_DIV    = 48828,
    parameter int SAMPLE_DIV  = 128,
    // Entry [ch*2**FRAME_BITS + f] = {period, dur}, entry 0 in the least significant bits.
    parameter logic [CHANNELS*(2**FRAME_BITS)*(PERIOD_BITS+DUR_BITS)-1:0] ROM_INIT = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop,
    output logic                          busy,
    output logic [$clog2(CHANNELS+1)-1:0] level,
    output logic                          audio
);

    localparam int DEPTH = 2**FRAME_BITS;
    localparam int EW    = PERIOD_BITS + DUR_BITS;
    localparam int LW    = $clog2(CHANNELS + 1);
    localparam int AW    = LW + 1;
    localparam int TW    = $clog2(TICK_DIV + 1);
    localparam int SW    = $clog2(SAMPLE_DIV + 1);

    logic [TW-1:0]       tick_cnt;
    logic [SW-1:0]       sample_cnt;
    logic                tick;
    logic                sample_step;
    logic [CHANNELS-1:0] square;
    logic [CHANNELS-1:0] playing;
    logic [LW-1:0]       square_sum;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_sum;

    assign tick        = busy && (tick_cnt == TW'(TICK_DIV - 1));
    assign sample_step = (sample_cnt == SW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || start) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else if (busy) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || sample_step) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_voice
        audio_voice #(
            .FRAME_BITS  (FRAME_BITS),
            .PERIOD_BITS (PERIOD_BITS),
            .DUR_BITS    (DUR_BITS)
        ) u_voice (
            .clk         (clk),
            .reset       (reset),
            .start       (start),
            .stop        (stop),
            .loop        (loop),
            .tick        (tick),
            .sample_step (sample_step),
            .frames      (ROM_INIT[ch*DEPTH*EW +: DEPTH*EW]),
            .square      (square[ch]),
            .playing     (playing[ch])
        );
    end

    always_comb begin
        square_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            square_sum = square_sum + LW'(square[i]);
        end
        acc_sum = acc + AW'(level);
    end

    // First-order sigma-delta: the residue stays below CHANNELS, so acc_sum never overflows AW bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            level <= '0;
            acc   <= '0;
            audio <= 1'b0;
        end else begin
            busy  <= |playing;
            level <= square_sum;
            if (acc_sum >= AW'(CHANNELS)) begin
                acc   <= acc_sum - AW'(CHANNELS);
                audio <= 1'b1;
            end else begin
                acc   <= acc_sum;
                audio <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_sequencer.sv
// tb/tb_audio_sequencer.sv - randomized check of audio_sequencer against a frame-table reference model
module tb_audio_sequencer;

    localparam int CH    = 2;
    localparam int PB    = 16;
    localparam int DB    = 10;
    localparam int TDIV  = 4;
    localparam int SDIV  = 2;
    localparam int DEPTH = 8;
    localparam int EW    = PB + DB;
    localparam int ROMW  = CH * DEPTH * EW;
    localparam int NDUT  = 3;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_DONE = 2;

    function automatic logic [EW-1:0] ent(input int p, input int d);
        return {PB'(p), DB'(d)};
    endfunction

    function automatic logic [ROMW-1:0] rom_a();
        logic [ROMW-1:0] r;
        r = '0;
        r[0*EW +: EW] = ent(3, 1);
        r[8*EW +: EW] = ent(0, 2);
        r[9*EW +: EW] = ent(1, 0);
        return r;
    endfunction

    function automatic logic [ROMW-1:0] rom_b();
        logic [ROMW-1:0] r;
        r = '0;
        for (int i = 0; i < CH * DEPTH; i++) r[i*EW +: EW] = ent(1, 0);
        return r;
    endfunction

    function automatic logic [ROMW-1:0] rom_c();
        logic [ROMW-1:0] r;
        r = '0;
        r[0*EW +: EW]  = ent(2, 0);
        r[1*EW +: EW]  = ent(5, 2);
        r[2*EW +: EW]  = ent(0, 1);
        r[3*EW +: EW]  = ent(4, 0);
        r[8*EW +: EW]  = ent(7, 3);
        r[9*EW +: EW]  = ent(1, 1);
        r[10*EW +: EW] = ent(3, 0);
        r[11*EW +: EW] = ent(2, 2);
        return r;
    endfunction

    localparam logic [ROMW-1:0] ROM_A = rom_a();
    localparam logic [ROMW-1:0] ROM_B = rom_b();
    localparam logic [ROMW-1:0] ROM_C = rom_c();

    logic       clk = 1'b0;
    logic       reset, start, stop, loop;
    logic       busy  [NDUT];
    logic [1:0] level [NDUT];
    logic       audio [NDUT];

    always #5 clk = ~clk;

    audio_sequencer #(.CHANNELS(CH), .FRAME_BITS(3), .PERIOD_BITS(PB), .DUR_BITS(DB),
                      .TICK_DIV(TDIV), .SAMPLE_DIV(SDIV), .ROM_INIT(ROM_A)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .busy(busy[0]), .level(level[0]), .audio(audio[0]));

    audio_sequencer #(.CHANNELS(CH), .FRAME_BITS(3), .PERIOD_BITS(PB), .DUR_BITS(DB),
                      .TICK_DIV(TDIV), .SAMPLE_DIV(SDIV), .ROM_INIT(ROM_B)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .busy(busy[1]), .level(level[1]), .audio(audio[1]));

    audio_sequencer #(.CHANNELS(CH), .FRAME_BITS(3), .PERIOD_BITS(PB), .DUR_BITS(DB),
                      .TICK_DIV(TDIV), .SAMPLE_DIV(SDIV), .ROM_INIT(ROM_C)) dut_c (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .busy(busy[2]), .level(level[2]), .audio(audio[2]));

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    // Reference model: per channel, ticks spent in the current frame and sample steps since the
    // period was loaded; the square is simply floor(samples / period) mod 2.
    logic [ROMW-1:0] rom_img [NDUT];
    int m_state   [NDUT][CH];
    int m_frame   [NDUT][CH];
    int m_ticks   [NDUT][CH];
    int m_period  [NDUT][CH];
    int m_samples [NDUT][CH];
    int m_busy_cycles [NDUT];
    int m_busy  [NDUT];
    int m_level [NDUT];
    int m_acc   [NDUT];
    int m_audio [NDUT];
    int m_cycle;

    function automatic int t_period(input int d, input int c, input int f);
        return int'(rom_img[d][(c*DEPTH + f)*EW + DB +: PB]);
    endfunction

    function automatic int t_dur(input int d, input int c, input int f);
        return int'(rom_img[d][(c*DEPTH + f)*EW +: DB]);
    endfunction

    function automatic int m_square(input int d, input int c);
        if (m_state[d][c] != M_PLAY || m_period[d][c] == 0) return 0;
        return (m_samples[d][c] / m_period[d][c]) % 2;
    endfunction

    task automatic m_load(input int d, input int c, input int f);
        m_frame[d][c]   = f;
        m_ticks[d][c]   = 0;
        m_period[d][c]  = t_period(d, c, f);
        m_samples[d][c] = 0;
    endtask

    task automatic model_step();
        bit smp;
        smp = (m_cycle % SDIV) == SDIV - 1;
        for (int d = 0; d < NDUT; d++) begin
            bit tk;
            int sq_sum;
            int any_play;
            int total;
            tk = (m_busy[d] != 0) && (m_busy_cycles[d] % TDIV == TDIV - 1);
            sq_sum = 0;
            any_play = 0;
            for (int c = 0; c < CH; c++) begin
                sq_sum += m_square(d, c);
                if (m_state[d][c] == M_PLAY) any_play = 1;
            end
            if (reset) begin
                m_busy_cycles[d] = 0;
                m_busy[d] = 0; m_level[d] = 0; m_acc[d] = 0; m_audio[d] = 0;
                for (int c = 0; c < CH; c++) begin
                    m_state[d][c] = M_IDLE;
                    m_load(d, c, 0);
                    m_period[d][c] = 0;
                end
            end else begin
                if (start) m_busy_cycles[d] = 0;
                else if (m_busy[d] != 0) m_busy_cycles[d]++;
                total = m_acc[d] + m_level[d];
                m_audio[d] = (total >= CH) ? 1 : 0;
                m_acc[d]   = (total >= CH) ? total - CH : total;
                m_level[d] = sq_sum;
                m_busy[d]  = any_play;
                for (int c = 0; c < CH; c++) begin
                    if (stop) begin
                        m_state[d][c] = M_IDLE;
                    end else if (start) begin
                        m_state[d][c] = M_PLAY;
                        m_load(d, c, 0);
                    end else if (m_state[d][c] == M_PLAY) begin
                        if (tk && m_ticks[d][c] == t_dur(d, c, m_frame[d][c])) begin
                            int nf;
                            nf = (m_frame[d][c] + 1) % DEPTH;
                            if (t_period(d, c, nf) == 0 && t_dur(d, c, nf) == 0) begin
                                if (loop) m_load(d, c, 0);
                                else m_state[d][c] = M_DONE;
                            end else begin
                                m_load(d, c, nf);
                            end
                        end else begin
                            if (tk) m_ticks[d][c]++;
                            if (smp && m_period[d][c] != 0) m_samples[d][c]++;
                        end
                    end
                end
            end
        end
        m_cycle = reset ? 0 : m_cycle + 1;
    endtask

    initial begin
        rom_img[0] = ROM_A;
        rom_img[1] = ROM_B;
        rom_img[2] = ROM_C;
        m_cycle = 0;
        for (int d = 0; d < NDUT; d++) begin
            m_busy_cycles[d] = 0; m_busy[d] = 0; m_level[d] = 0; m_acc[d] = 0; m_audio[d] = 0;
            for (int c = 0; c < CH; c++) begin
                m_state[d][c] = M_IDLE; m_frame[d][c] = 0; m_ticks[d][c] = 0;
                m_period[d][c] = 0; m_samples[d][c] = 0;
            end
        end
    end

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < NDUT; d++) begin
                check_eq($sformatf("busy[%0d]", d), int'(busy[d]), m_busy[d]);
                check_eq($sformatf("level[%0d]", d), int'(level[d]), m_level[d]);
                check_eq($sformatf("audio[%0d]", d), int'(audio[d]), m_audio[d]);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int busy_hi;
        int ones;
        int odd_level;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            check_eq("reset_busy", int'(busy[d]), 0);
            check_eq("reset_level", int'(level[d]), 0);
            check_eq("reset_audio", int'(audio[d]), 0);
        end
        reset = 1'b0;
        @(negedge clk);

        pulse_start();
        repeat (60) @(negedge clk);
        check_eq("noloop_a_done", int'(busy[0]), 0);
        check_eq("noloop_c_done", int'(busy[2]), 0);
        check_eq("nomarker_b_wraps", int'(busy[1]), 1);

        loop = 1'b1;
        pulse_start();
        repeat (2) @(negedge clk);
        busy_hi = 0;
        repeat (400) begin
            @(negedge clk);
            busy_hi += int'(busy[0]);
        end
        check_eq("loop_busy_400", busy_hi, 400);

        ones = 0;
        odd_level = 0;
        repeat (64) begin
            @(negedge clk);
            ones += int'(audio[1]);
            if (level[1] == 2'd1) odd_level++;
        end
        check_eq("inphase_audio_ones", ones, 32);
        check_eq("inphase_level_odd", odd_level, 0);

        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check_eq("stopstart_busy", int'(busy[d]), 0);
            check_eq("stopstart_level", int'(level[d]), 0);
            check_eq("stopstart_audio", int'(audio[d]), 0);
        end

        pulse_start();
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check_eq("midreset_busy", int'(busy[d]), 0);
            check_eq("midreset_level", int'(level[d]), 0);
            check_eq("midreset_audio", int'(audio[d]), 0);
        end
        reset = 1'b0;

        repeat (4000) begin
            @(negedge clk);
            start = ($urandom_range(0, 149) == 0);
            stop  = ($urandom_range(0, 399) == 0);
            reset = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 99) == 0) loop = ~loop;
        end
        start = 1'b0; stop = 1'b0; reset = 1'b0;
        repeat (10) @(negedge clk);
        checking = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
